// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_MISS,
    ST_OVER
  } state_e;

  localparam logic [9:0] FRAME_TICK_X = 10'd0;
  localparam logic [9:0] FRAME_TICK_Y = 10'd480;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD score counter: synchronous clear, increment saturating at 99,
// and a ones_wrap_o strobe marking increments that roll the ones digit 9 -> 0.
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic       clk25,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output bcd_digit_t tens_o,
  output bcd_digit_t ones_o,
  output logic       ones_wrap_o
);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;
  logic       sat;

  assign sat         = (tens_q == BCD_NINE) && (ones_q == BCD_NINE);
  assign ones_wrap_o = inc_i && !clr_i && !sat && (ones_q == BCD_NINE);
  assign tens_o      = tens_q;
  assign ones_o      = ones_q;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc_i && !sat) begin
      if (ones_q == BCD_NINE) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/pong_sequencer.sv
// Match flow controller for pong: idle, serve, play, miss and game over, with
// score, lives and ball control. Optional speed stepping under PONG_SPEEDUP_EN.
module pong_sequencer
  import pong_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 63
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic       button,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       missed,
  output logic [1:0] lives_left,
  output logic [7:0] score,
  output logic       game_over,
  output logic [1:0] speed
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);

  state_e     state_q;
  logic [7:0] frame_cnt_q;
  logic       btn_q;
  logic       hit_seen_q;
  logic       miss_seen_q;
  logic       ball_reset_q;
  logic       ball_run_q;
  logic       missed_q;
  logic [1:0] lives_q;
  logic       game_over_q;

  logic       frame_tick;
  logic       btn_rise;
  logic       in_play;
  logic       hit_eff;
  logic       miss_eff;
  logic       score_clr;
  logic       score_inc;
  logic       ones_wrap;
  bcd_digit_t score_tens;
  bcd_digit_t score_ones;

  assign frame_tick = (xpos == FRAME_TICK_X) && (ypos == FRAME_TICK_Y);
  assign btn_rise   = frame_tick && button && !btn_q;
  assign in_play    = (state_q == ST_PLAY);

  // An event arriving on the tick cycle itself still belongs to the ending frame.
  assign hit_eff    = hit_seen_q || (hit && in_play);
  assign miss_eff   = miss_seen_q || (miss && in_play);

  assign score_clr  = frame_tick && (state_q == ST_IDLE) && btn_rise;
  assign score_inc  = frame_tick && in_play && hit_eff && !miss_eff;

  pong_bcd_counter u_score (
    .clk25       (clk25),
    .reset       (reset),
    .clr_i       (score_clr),
    .inc_i       (score_inc),
    .tens_o      (score_tens),
    .ones_o      (score_ones),
    .ones_wrap_o (ones_wrap)
  );

  always_ff @(posedge clk25) begin
    if (reset || frame_tick || !in_play) begin
      hit_seen_q  <= 1'b0;
      miss_seen_q <= 1'b0;
    end else begin
      if (hit)  hit_seen_q  <= 1'b1;
      if (miss) miss_seen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      btn_q        <= 1'b1;
      ball_reset_q <= 1'b0;
      ball_run_q   <= 1'b0;
      missed_q     <= 1'b0;
      lives_q      <= LIVES_INIT;
      game_over_q  <= 1'b0;
    end else begin
      ball_reset_q <= 1'b0;
      if (frame_tick) begin
        btn_q <= button;
        case (state_q)
          ST_IDLE: begin
            if (btn_rise) begin
              lives_q      <= LIVES_INIT;
              ball_reset_q <= 1'b1;
              frame_cnt_q  <= '0;
              state_q      <= ST_SERVE;
            end
          end
          ST_SERVE: begin
            if (frame_cnt_q == SERVE_LAST) begin
              frame_cnt_q <= '0;
              ball_run_q  <= 1'b1;
              state_q     <= ST_PLAY;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
          ST_PLAY: begin
            if (miss_eff) begin
              ball_run_q <= 1'b0;
              if (lives_q == 2'd1) begin
                lives_q     <= 2'd0;
                game_over_q <= 1'b1;
                state_q     <= ST_OVER;
              end else begin
                lives_q     <= lives_q - 2'd1;
                missed_q    <= 1'b1;
                frame_cnt_q <= '0;
                state_q     <= ST_MISS;
              end
            end
          end
          ST_MISS: begin
            if (frame_cnt_q == MISS_LAST) begin
              frame_cnt_q  <= '0;
              missed_q     <= 1'b0;
              ball_reset_q <= 1'b1;
              state_q      <= ST_SERVE;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
          ST_OVER: begin
            if (btn_rise) begin
              game_over_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [1:0] speed_q;

  // Steps once per ten points; the counter never wraps once saturated at 99.
  always_ff @(posedge clk25) begin
    if (reset || score_clr) begin
      speed_q <= 2'd0;
    end else if (ones_wrap && (speed_q != 2'd3)) begin
      speed_q <= speed_q + 2'd1;
    end
  end

  assign speed = speed_q;
`else
  logic unused_wrap;
  assign unused_wrap = ones_wrap;
  assign speed       = 2'd0;
`endif

  assign ball_reset = ball_reset_q;
  assign ball_run   = ball_run_q;
  assign missed     = missed_q;
  assign lives_left = lives_q;
  assign score      = {score_tens, score_ones};
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_sequencer.sv
// Randomized scoreboard bench for pong_sequencer against a frame-level game model.
module tb_pong_sequencer;

  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int MISS_FRAMES  = 63;
  localparam int FL           = 10;  // cycles per emulated video frame

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_MISS  = 3;
  localparam int P_OVER  = 4;

  typedef struct packed {
    logic       br;
    logic       run;
    logic       mis;
    logic [1:0] lives;
    logic [7:0] score;
    logic       over;
    logic [1:0] spd;
  } exp_t;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xpos  = 10'd0;
  logic [9:0] ypos  = 10'd0;
  logic       button = 1'b0;
  logic       hit    = 1'b0;
  logic       miss   = 1'b0;
  logic       ball_reset, ball_run, missed, game_over;
  logic [1:0] lives_left, speed;
  logic [7:0] score;

  pong_sequencer dut (
    .clk25      (clk25),
    .reset      (reset),
    .xpos       (xpos),
    .ypos       (ypos),
    .button     (button),
    .hit        (hit),
    .miss       (miss),
    .ball_reset (ball_reset),
    .ball_run   (ball_run),
    .missed     (missed),
    .lives_left (lives_left),
    .score      (score),
    .game_over  (game_over),
    .speed      (speed)
  );

  always #5 clk25 = ~clk25;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fc    = 0;

  // Behavioural game model
  int m_phase, m_left, m_lives, m_score;
  bit m_btn_prev, m_hit_f, m_miss_f, m_br;

  function automatic exp_t model_out();
    exp_t e;
    e.br    = m_br;
    e.run   = (m_phase == P_PLAY);
    e.mis   = (m_phase == P_MISS);
    e.lives = 2'(m_lives);
    e.score = {4'(m_score / 10), 4'(m_score % 10)};
    e.over  = (m_phase == P_OVER);
`ifdef PONG_SPEEDUP_EN
    e.spd   = 2'((m_score / 10 > 3) ? 3 : m_score / 10);
`else
    e.spd   = 2'd0;
`endif
    return e;
  endfunction

  task automatic model_step();
    bit tick, rise;
    tick = (xpos == 10'd0) && (ypos == 10'd480);
    if (reset) begin
      m_phase = P_IDLE; m_left = 0; m_lives = LIVES; m_score = 0;
      m_btn_prev = 1'b1; m_hit_f = 1'b0; m_miss_f = 1'b0; m_br = 1'b0;
      return;
    end
    m_br = 1'b0;
    if (m_phase == P_PLAY) begin
      m_hit_f  = m_hit_f | hit;
      m_miss_f = m_miss_f | miss;
    end
    if (tick) begin
      rise = button && !m_btn_prev;
      m_btn_prev = button;
      case (m_phase)
        P_IDLE: if (rise) begin
          m_lives = LIVES; m_score = 0; m_br = 1'b1;
          m_phase = P_SERVE; m_left = SERVE_FRAMES;
        end
        P_SERVE: begin
          m_left--;
          if (m_left == 0) m_phase = P_PLAY;
        end
        P_PLAY: begin
          if (m_miss_f) begin
            if (m_lives == 1) begin
              m_lives = 0; m_phase = P_OVER;
            end else begin
              m_lives--; m_phase = P_MISS; m_left = MISS_FRAMES;
            end
          end else if (m_hit_f) begin
            m_score = (m_score >= 99) ? 99 : m_score + 1;
          end
        end
        P_MISS: begin
          m_left--;
          if (m_left == 0) begin
            m_br = 1'b1; m_phase = P_SERVE; m_left = SERVE_FRAMES;
          end
        end
        P_OVER: if (rise) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      m_hit_f = 1'b0; m_miss_f = 1'b0;
    end
    if (m_phase != P_PLAY) begin
      m_hit_f = 1'b0; m_miss_f = 1'b0;
    end
  endtask

  // One clock of stimulus; the model sees exactly what the DUT samples.
  task automatic drive_cycle(input bit rst, input bit btn, input int hit_pct, input int miss_pct);
    int mode;
    reset  = rst;
    button = btn;
    if (fc == 0) begin
      xpos = 10'd0; ypos = 10'd480; hit = 1'b0; miss = 1'b0;
    end else begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        xpos = 10'd0; ypos = 10'($urandom_range(0, 479));
      end else if (mode == 1) begin
        xpos = 10'($urandom_range(1, 799)); ypos = 10'd480;
      end else begin
        xpos = 10'($urandom_range(1, 1023)); ypos = 10'($urandom_range(0, 1023));
      end
      hit  = ($urandom_range(0, 99) < hit_pct);
      miss = ($urandom_range(0, 99) < miss_pct);
    end
    @(posedge clk25);
    model_step();
    exp_q.push_back(model_out());
    #1;
    fc = (fc + 1) % FL;
  endtask

  bit btn_level = 1'b0;

  // btn_mode: 0 low, 1 high, 2 random level changes at frame boundaries
  task automatic run_frames(input int n, input int btn_mode, input int hit_pct, input int miss_pct);
    for (int f = 0; f < n; f++) begin
      if (btn_mode == 0) btn_level = 1'b0;
      else if (btn_mode == 1) btn_level = 1'b1;
      else if ($urandom_range(0, 5) == 0) btn_level = ~btn_level;
      for (int c = 0; c < FL; c++) drive_cycle(1'b0, btn_level, hit_pct, miss_pct);
    end
  endtask

  // Monitor: compare every output sample against the scoreboard
  exp_t prev_exp = '0;
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk25);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ball_reset, ball_run, missed, lives_left, score, game_over, speed};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got br=%0b run=%0b mis=%0b lives=%0d score=%h over=%0b spd=%0d want br=%0b run=%0b mis=%0b lives=%0d score=%h over=%0b spd=%0d",
                   $time, a.br, a.run, a.mis, a.lives, a.score, a.over, a.spd,
                   e.br, e.run, e.mis, e.lives, e.score, e.over, e.spd);
        end
        if (e != prev_exp) begin
          $display("t=%0t txn br=%0b run=%0b mis=%0b lives=%0d score=%h over=%0b spd=%0d",
                   $time, e.br, e.run, e.mis, e.lives, e.score, e.over, e.spd);
          prev_exp = e;
        end
      end
    end
  end

  initial begin
    int guard;
    // Reset with the button held: must not start a match afterwards.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 0, 0);
    run_frames(3, 1, 0, 0);
    run_frames(5, 0, 0, 0);
    // Start, serve, then a long hit-only run that saturates the score.
    run_frames(200, 1, 50, 0);
    // Reset in the middle of play.
    drive_cycle(1'b1, 1'b1, 50, 0);
    run_frames(5, 0, 0, 0);
    // Mixed random matches: misses, game overs, held and fresh presses.
    for (int s = 0; s < 8; s++) begin
      run_frames(150, 2, 40, 1);
      run_frames(100, 2, 20, 4);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk25);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(negedge clk25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_sequencer.md
# pong_sequencer

Game-flow controller for the pong datapath. It sits beside `game` in `pong` on the `clk25` domain and sequences each match: idle, serve delay, play, miss penalty and game over. It decides when the ball is reloaded and when it may move, and it keeps score, lives and the miss-flash indication. `game` consumes its `ball_reset`, `ball_run`, `missed` and `speed` outputs; in return `game` reports paddle hits and bottom-wall misses.

## Interface
Parameters:
- `LIVES`, 3: lives per match, range 1..3.
- `SERVE_FRAMES`, 60: frames the ball is held before a serve, range 1..255.
- `MISS_FRAMES`, 63: frames of miss flash and pause, range 1..255.

Ports:
- `clk25`, in, 1: 25 MHz pixel clock; the only clock.
- `reset`, in, 1: synchronous reset, active-high.
- `xpos`, in, 10: pixel column from `video_timer`.
- `ypos`, in, 10: pixel line from `video_timer`.
- `button`, in, 1: start/serve button, level.
- `hit`, in, 1: ball-on-paddle bounce; may be high on many cycles per frame.
- `miss`, in, 1: ball touched bottom border; may be high on many cycles per frame.
- `ball_reset`, out, 1: one-cycle pulse; `game` reloads the ball to its start position.
- `ball_run`, out, 1: ball may move at end of frame.
- `missed`, out, 1: miss-flash enable, which drives red screen.
- `lives_left`, out, 2: remaining lives.
- `score`, out, 8: two BCD digits; [7:4] holds tens, [3:0] holds ones.
- `game_over`, out, 1: high while in OVER.
- `speed`, out, 2: ball step select; 0 means 2 px per frame.

## Operation
- `frame_tick` = (`xpos`==0 && `ypos`==480), decoded combinationally. All per-frame actions occur on that cycle.
- `button` is sampled only on `frame_tick` into `btn_q`. `btn_rise` = `button` && !`btn_q` on a `frame_tick`.
- `hit_seen` and `miss_seen` are sticky flags.
  - They are set by `hit`/`miss` while in PLAY.
  - They are consumed and cleared on `frame_tick`.
  - At most one hit and one miss are counted per frame.
- States:
  - **IDLE**: On `btn_rise`, load `lives_left`=LIVES, `score`=0, `speed`=0, pulse `ball_reset`, then go to SERVE.
  - **SERVE**: `frame_cnt` counts `frame_tick`s. When it reaches SERVE_FRAMES, go to PLAY and clear `frame_cnt`.
  - **PLAY**: `ball_run`=1. On `frame_tick`:
    - If `miss_seen`: if `lives_left`==1, go to OVER with `lives_left`=0; otherwise decrement `lives_left` and go to MISS.
    - Else if `hit_seen`: increment `score` in BCD. The increment saturates at 0x99.
  - **MISS**: `ball_run`=0 and `missed`=1. After MISS_FRAMES `frame_tick`s, pulse `ball_reset` and go to SERVE.
  - **OVER**: `game_over`=1 and `ball_run`=0. `score` holds its value. On `btn_rise`, go to IDLE.
- Miss has priority over hit in the same frame; that hit is discarded.
- `hit`/`miss` outside PLAY are ignored, and the flags are held clear there.
- `button` held through reset or through OVER entry does not start or restart a match; a fresh rising edge is required.

## Timing
- Reset values: state IDLE, `ball_reset`=0, `ball_run`=0, `missed`=0, `lives_left`=LIVES, `score`=0x00, `game_over`=0, `speed`=0. Also `frame_cnt`=0, `btn_q`=1, and both seen-flags 0.
- All outputs are registered. A decision made on `frame_tick` cycle N is visible at cycle N+1.
- `ball_reset` is high for exactly one cycle (N+1). This precedes `game`'s next end-of-frame by a full frame.
- SERVE lasts exactly SERVE_FRAMES frames; MISS lasts exactly MISS_FRAMES frames.
- `reset` asserted mid-operation returns to the reset state on the next edge. No pulse is emitted.

## Configuration
- Macro: `PONG_SPEEDUP_EN`.
- When defined:
  - `speed` increments, saturating at 3, on each hit that wraps the ones digit from 9 to 0. In other words, it steps every 10 points.
  - `speed` is kept across misses and cleared on new match start.
  - It does not step once the score has saturated at 0x99.
- When undefined: `speed` is constant 0, and the logic is removed.

## Structure
- `pong_pkg`:
  - State enum: IDLE, SERVE, PLAY, MISS, OVER.
  - `FRAME_TICK_Y`=480, `FRAME_TICK_X`=0.
  - BCD digit typedef.
- Sub-module `pong_bcd_counter`: 2-digit BCD counter with increment, clear and saturate-at-99 behaviour. It also provides a `ones_wrap` strobe that feeds `speed`.

## Test plan
- **Reset and idle:** reset, then 5 frames with `button`=0 → IDLE; `lives_left`=3, `score`=0x00, no `ball_reset`.
- **Start and serve:** `button` rises before frame k → `ball_reset` 1 cycle after tick k; `ball_run` rises exactly 60 frames later.
- **Hit counting:** in PLAY, `hit` high 8 cycles within one frame, over 12 frames → `score`=0x12. With the macro, `speed`=1 after the 10th hit; without it, `speed`=0.
- **Miss with priority:** `hit` and `miss` in the same frame → `score` unchanged, `lives_left` 3→2, `missed`=1 for 63 frames, then `ball_reset` pulse and SERVE.
- **Game over and restart:** 3 misses → OVER with `game_over`=1 and `lives_left`=0. `button` held continuously produces no restart. Release, then press → IDLE, then a fresh press starts a match with `score`=0x00.
- **Saturation and mid-game reset:** preload 99 hits → `score` stays 0x99. `reset` pulsed mid-PLAY → all outputs at reset values next cycle.
